// File: rtl/svf_sequencer.sv
// Sample-rate sequencer for the state-variable filter: pops one upstream sample per tick,
// issues it with shadowed coefficients, and forwards the filter's answer to the DAC path.
module svf_sequencer #(
  parameter int CLKS_PER_SAMPLE = 2500,
  parameter int TIMEOUT         = 8,
  parameter int W               = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] src_x,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_F,
  input  logic [W-1:0] cfg_Q,
  input  logic [1:0]   cfg_sel,
  output logic         svf_in_valid,
  output logic [W-1:0] svf_x,
  output logic [W-1:0] svf_F,
  output logic [W-1:0] svf_Q,
  output logic [1:0]   svf_sel,
  input  logic [W-1:0] svf_y,
  input  logic         svf_out_valid,
  output logic [W-1:0] dac_sample,
  output logic         dac_valid,
  output logic [15:0]  underrun_cnt,
  output logic [15:0]  overrun_cnt,
  output logic         timeout_flag,
  input  logic         stat_clr
);

  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  Q_ONE    = W'(32'h0001_0000);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  wait_q, wait_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   act_f_q, act_f_d, act_q_q, act_q_d;
  logic [1:0]     act_sel_q, act_sel_d;
  logic [W-1:0]   pend_f_q, pend_f_d, pend_q_q, pend_q_d;
  logic [1:0]     pend_sel_q, pend_sel_d;
  logic           in_valid_q, in_valid_d;
  logic [W-1:0]   dac_q, dac_d;
  logic           dac_valid_q, dac_valid_d;
  logic [15:0]    under_q, under_d, over_q, over_d;
  logic           flag_q, flag_d;

  logic tick;
  logic under_inc, over_inc, flag_set;

  assign tick      = enable && (cnt_q == CNT_MAX);
  assign src_ready = tick && (state_q == ST_IDLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wait_d      = wait_q;
    x_d         = x_q;
    act_f_d     = act_f_q;
    act_q_d     = act_q_q;
    act_sel_d   = act_sel_q;
    dac_d       = dac_q;
    in_valid_d  = 1'b0;
    dac_valid_d = 1'b0;
    under_inc   = 1'b0;
    over_inc    = 1'b0;
    flag_set    = 1'b0;

    if (!enable)             cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);

    // Pending set is visible to the same-cycle issue, so a coinciding write takes effect.
    pend_f_d   = cfg_we ? cfg_F   : pend_f_q;
    pend_q_d   = cfg_we ? cfg_Q   : pend_q_q;
    pend_sel_d = cfg_we ? cfg_sel : pend_sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          x_d        = src_valid ? src_x : '0;
          under_inc  = !src_valid;
          act_f_d    = pend_f_d;
          act_q_d    = pend_q_d;
          act_sel_d  = pend_sel_d;
          in_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (svf_out_valid) begin
          dac_d       = svf_y;
          dac_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          flag_set = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    over_inc = tick && (state_q != ST_IDLE);

    // Clear has priority over a same-cycle increment or flag set.
    if (stat_clr) begin
      under_d = '0;
      over_d  = '0;
      flag_d  = 1'b0;
    end else begin
      under_d = under_inc ? sat_inc(under_q) : under_q;
      over_d  = over_inc  ? sat_inc(over_q)  : over_q;
      flag_d  = flag_q | flag_set;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      x_q         <= '0;
      act_f_q     <= '0;
      act_q_q     <= Q_ONE;
      act_sel_q   <= 2'b00;
      pend_f_q    <= '0;
      pend_q_q    <= Q_ONE;
      pend_sel_q  <= 2'b00;
      in_valid_q  <= 1'b0;
      dac_q       <= '0;
      dac_valid_q <= 1'b0;
      under_q     <= '0;
      over_q      <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      x_q         <= x_d;
      act_f_q     <= act_f_d;
      act_q_q     <= act_q_d;
      act_sel_q   <= act_sel_d;
      pend_f_q    <= pend_f_d;
      pend_q_q    <= pend_q_d;
      pend_sel_q  <= pend_sel_d;
      in_valid_q  <= in_valid_d;
      dac_q       <= dac_d;
      dac_valid_q <= dac_valid_d;
      under_q     <= under_d;
      over_q      <= over_d;
      flag_q      <= flag_d;
    end
  end

  assign svf_in_valid = in_valid_q;
  assign svf_x        = x_q;
  assign svf_F        = act_f_q;
  assign svf_Q        = act_q_q;
  assign svf_sel      = act_sel_q;
  assign dac_sample   = dac_q;
  assign dac_valid    = dac_valid_q;
  assign underrun_cnt = under_q;
  assign overrun_cnt  = over_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_svf_sequencer.sv
// Randomised bench for svf_sequencer: a timestamp-based transaction model predicts every
// output each cycle while a stand-in filter answers in_valid after a chosen latency.
module tb_svf_sequencer;
  localparam int CLKS = 16;
  localparam int TMO  = 20;
  localparam int W    = 21;
  localparam logic [W-1:0] Q_ONE = 21'h10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, src_valid, src_ready, cfg_we, stat_clr;
  logic [W-1:0] src_x, cfg_F, cfg_Q;
  logic [1:0]   cfg_sel;
  logic         svf_in_valid, svf_out_valid, dac_valid, timeout_flag;
  logic [W-1:0] svf_x, svf_F, svf_Q, svf_y, dac_sample;
  logic [1:0]   svf_sel;
  logic [15:0]  underrun_cnt, overrun_cnt;

  always #5 clk = ~clk;

  svf_sequencer #(.CLKS_PER_SAMPLE(CLKS), .TIMEOUT(TMO), .W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_x(src_x), .src_valid(src_valid), .src_ready(src_ready),
    .cfg_we(cfg_we), .cfg_F(cfg_F), .cfg_Q(cfg_Q), .cfg_sel(cfg_sel),
    .svf_in_valid(svf_in_valid), .svf_x(svf_x), .svf_F(svf_F), .svf_Q(svf_Q),
    .svf_sel(svf_sel), .svf_y(svf_y), .svf_out_valid(svf_out_valid),
    .dac_sample(dac_sample), .dac_valid(dac_valid),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt),
    .timeout_flag(timeout_flag), .stat_clr(stat_clr)
  );

  int total = 0;
  int bad   = 0;

  // Model: cycle index, tick phase, and the cycle the current sample was issued.
  int           k, phase, issue_cyc;
  bit           in_flight;
  logic [W-1:0] e_x, e_f, e_q, e_dac, p_f, p_q;
  logic [1:0]   e_sel, p_sel;
  bit           e_iv, e_dv, e_flag;
  int           e_under, e_over;

  // Stand-in filter.
  int           fix_lat;
  bit           rnd_lat, spur;
  int           resp_at;
  logic [W-1:0] resp_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [W-1:0] y_of(input logic [W-1:0] x, input logic [1:0] sel);
    logic [W-1:0] s3;
    s3 = x + x + x;
    return s3 + W'(sel) + W'(1);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic bit model_waiting();
    return in_flight && (k > issue_cyc);
  endfunction

  task automatic model_reset();
    phase = 0; in_flight = 0; issue_cyc = 0;
    e_x = '0; e_f = '0; e_q = Q_ONE; e_sel = '0; e_dac = '0;
    p_f = '0; p_q = Q_ONE; p_sel = '0;
    e_iv = 0; e_dv = 0; e_flag = 0; e_under = 0; e_over = 0;
  endtask

  // Applies the inputs of cycle k (still on the pins) and moves the model to cycle k+1.
  task automatic model_advance();
    bit busy, tick;
    busy = in_flight;
    tick = enable && (phase == CLKS - 1);
    e_iv = 0;
    e_dv = 0;
    if (cfg_we) begin
      p_f = cfg_F; p_q = cfg_Q; p_sel = cfg_sel;
    end
    if (busy && k > issue_cyc) begin
      if (svf_out_valid) begin
        e_dac = y_of(e_x, e_sel); e_dv = 1; in_flight = 0;
      end else if (k == issue_cyc + TMO) begin
        e_flag = 1; in_flight = 0;
      end
    end
    if (tick) begin
      if (!busy) begin
        e_x = src_valid ? src_x : '0;
        if (!src_valid) e_under = sat(e_under);
        e_f = p_f; e_q = p_q; e_sel = p_sel;
        e_iv = 1; in_flight = 1; issue_cyc = k + 1;
      end else begin
        e_over = sat(e_over);
      end
    end
    if (stat_clr) begin
      e_under = 0; e_over = 0; e_flag = 0;
    end
    phase = enable ? (phase + 1) % CLKS : 0;
    k++;
  endtask

  task automatic compare_all();
    check("in_valid",  32'(svf_in_valid), 32'(e_iv));
    check("svf_x",     32'(svf_x),        32'(e_x));
    check("svf_F",     32'(svf_F),        32'(e_f));
    check("svf_Q",     32'(svf_Q),        32'(e_q));
    check("svf_sel",   32'(svf_sel),      32'(e_sel));
    check("dac_sample",32'(dac_sample),   32'(e_dac));
    check("dac_valid", 32'(dac_valid),    32'(e_dv));
    check("underrun",  32'(underrun_cnt), 32'(e_under));
    check("overrun",   32'(overrun_cnt),  32'(e_over));
    check("timeout",   32'(timeout_flag), 32'(e_flag));
  endtask

  task automatic drive(input bit en, input bit sv, input logic [W-1:0] x, input bit we,
                       input logic [W-1:0] f, input logic [W-1:0] q, input logic [1:0] sel,
                       input bit clr);
    enable = en; src_valid = sv; src_x = x; cfg_we = we;
    cfg_F = f; cfg_Q = q; cfg_sel = sel; stat_clr = clr;
  endtask

  // One clock: update model, compare registered outputs, drive next inputs, then src_ready.
  task automatic step(input bit en, input bit sv, input logic [W-1:0] x, input bit we,
                      input logic [W-1:0] f, input logic [W-1:0] q, input logic [1:0] sel,
                      input bit clr);
    int l;
    @(negedge clk);
    model_advance();
    compare_all();
    if (svf_in_valid === 1'b1) begin
      l = rnd_lat ? int'($urandom_range(0, 21)) : fix_lat;
      resp_at = (l == 0) ? -1 : k + l;
      resp_y  = y_of(svf_x, svf_sel);
    end
    drive(en, sv, x, we, f, q, sel, clr);
    svf_out_valid = 1'b0;
    svf_y         = W'($urandom);
    if (k == resp_at) begin
      svf_out_valid = 1'b1;
      svf_y         = resp_y;
    end else if (spur && !model_waiting() && $urandom_range(0, 7) == 0) begin
      svf_out_valid = 1'b1;
    end
    #1;
    check("src_ready", 32'(src_ready),
          32'(en && (phase == CLKS - 1) && !in_flight));
  endtask

  // Asserts reset asynchronously between edges and checks the outputs before the next edge.
  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_src_ready", 32'(src_ready), 32'd0);
    repeat (2) @(negedge clk);
    drive(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    svf_out_valid = 1'b0;
    resp_at       = -1;
    rst           = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rx, rf, rq;
    logic [1:0]   rs;
    bit           ren, rsv, rwe, rclr;
    int           en_off;
    bit           reached;

    rst = 1'b0;
    drive(0, 0, '0, 0, '0, Q_ONE, 2'b00, 0);
    svf_out_valid = 1'b0; svf_y = '0;
    k = 0; resp_at = -1; resp_y = '0;
    fix_lat = 2; rnd_lat = 0; spur = 0;
    @(negedge clk);
    do_reset();

    // Nominal stream of constant samples, latency 2.
    for (int i = 0; i < 16; i++) step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    check("first_in_valid", 32'(svf_in_valid), 32'd1);
    for (int i = 0; i < 16 * 6; i++) step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    check("dac_nominal", 32'(dac_sample), 32'(y_of(21'h01000, 2'b00)));

    // Source dry for exactly three ticks.
    for (int i = 0; i < 48; i++) step(1, 0, 21'h00777, 0, '0, Q_ONE, 2'b00, 0);
    for (int i = 0; i < 8; i++)  step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    check("underrun_3", 32'(underrun_cnt), 32'd3);

    // Coefficient write in mid-period; must only appear at the next issue.
    for (int i = 0; i < 3; i++)  step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    step(1, 1, 21'h01000, 1, 21'h00800, Q_ONE, 2'b01, 0);
    check("F_held", 32'(svf_F), 32'd0);
    for (int i = 0; i < 24; i++) step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    check("F_applied", 32'(svf_F), 32'h00800);

    // Filter never answers.
    fix_lat = 0;
    for (int i = 0; i < 40; i++) step(1, 1, 21'h00321, 0, '0, Q_ONE, 2'b00, 0);
    check("timeout_set", 32'(timeout_flag), 32'd1);
    fix_lat = 2;
    for (int i = 0; i < 32; i++) step(1, 1, 21'h00400, 0, '0, Q_ONE, 2'b00, 0);
    step(1, 1, 21'h00400, 0, '0, Q_ONE, 2'b00, 1);
    step(1, 1, 21'h00400, 0, '0, Q_ONE, 2'b00, 0);
    check("clr_flag", 32'(timeout_flag), 32'd0);
    check("clr_under", 32'(underrun_cnt), 32'd0);

    // Slow filter so the next tick lands while waiting.
    fix_lat = 15;
    for (int i = 0; i < 80; i++) step(1, 1, 21'h00abc, 0, '0, Q_ONE, 2'b00, 0);
    check("overrun_seen", 32'(overrun_cnt != 16'd0), 32'd1);
    fix_lat = 2;

    // Random traffic: latencies, dropouts, config writes, clears, enable gaps, stray strobes.
    rnd_lat = 1; spur = 1; en_off = 0;
    for (int i = 0; i < 900; i++) begin
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 99) == 0) en_off = $urandom_range(1, 20);
      ren  = (en_off == 0);
      rsv  = ($urandom_range(0, 3) != 0);
      rx   = W'($urandom);
      rwe  = ($urandom_range(0, 11) == 0);
      rf   = W'($urandom);
      rq   = W'($urandom);
      rs   = 2'($urandom);
      rclr = ($urandom_range(0, 127) == 0);
      step(ren, rsv, rx, rwe, rf, rq, rs, rclr);
    end

    // Reset while waiting on the filter.
    rnd_lat = 0; spur = 0; fix_lat = 6;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step(1, 1, 21'h00123, 0, '0, Q_ONE, 2'b00, 0);
      reached = model_waiting();
    end
    check("reach_wait", 32'(reached), 32'd1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);
    check("in_valid_after_rst", 32'(svf_in_valid), 32'd1);
    for (int i = 0; i < 30; i++) step(1, 1, 21'h01000, 0, '0, Q_ONE, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
